// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: register-index width, register count and the x0 index.
package riscv_pkg;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;
endpackage

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard that tracks registers with a load in flight. It stalls ID on
// RAW/WAW hazards against those loads, or when no load-tracking slot is free.
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_LOADS = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_is_load,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic                 stall,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_bubble,
  output logic [2:0]           outstanding,
  output logic [CNT_W-1:0]     stall_cycles
  ,output logic                wb_err
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                wb_err_q, wb_err_d;

  logic [NUM_REGS-1:0] pend_vis, eff;
  logic [2:0]          cnt_vis;
  logic                clr, raw, waw, full, issue;

  // While rst is high, the decision already sees the state it is about to be reset to.
  assign pend_vis = rst ? '0 : pending_q;
  assign cnt_vis  = rst ? '0 : cnt_q;

  // A writeback to a register that is not pending leaves cnt unchanged, so it is not a clear.
  assign clr = wb_valid & (wb_rd != REG_X0) & pend_vis[wb_rd];

  // NOTE: every signal written in always_comb is given a default first, so no latch can be inferred.
  always_comb begin
    eff = pend_vis;
    if (clr) eff[wb_rd] = 1'b0;
    raw   = (id_use_rs1 & (id_rs1 != REG_X0) & eff[id_rs1])
          | (id_use_rs2 & (id_rs2 != REG_X0) & eff[id_rs2]);
    waw   = id_reg_write & (id_rd != REG_X0) & eff[id_rd];
    full  = id_is_load & ({1'b0, cnt_vis} == 4'(MAX_LOADS) + {3'b000, clr});
    stall = id_valid & ~flush & (raw | waw | full);
    issue = id_valid & ~flush & ~stall & id_is_load & id_reg_write & (id_rd != REG_X0);
  end

  assign pc_write     = ~stall;
  assign if_id_write  = ~stall;
  assign id_ex_bubble = stall | flush;
  assign outstanding  = cnt_q;
  assign stall_cycles = stall_cnt_q;
  assign wb_err       = wb_err_q;

  always_comb begin
    pending_d = pending_q;
    if (clr)   pending_d[wb_rd] = 1'b0;
    // Issue is applied after the clear, so a same-register set wins.
    if (issue) pending_d[id_rd] = 1'b1;
    cnt_d       = cnt_q + {2'b00, issue} - {2'b00, clr};
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    wb_err_d    = wb_err_q | (wb_valid & ~clr);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      wb_err_q    <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard. It compares the DUT against a model
// that keeps in-flight loads as a queue of destination registers.
module tb_hazard_scoreboard;
  localparam int unsigned ML    = 2;
  localparam int unsigned CNT_W = 6;

  typedef struct {
    bit rst, v, u1, u2, rw, ld, fl, wbv;
    logic [4:0] rs1, rs2, rd, wbr;
  } in_t;

  logic clk = 1'b0;
  logic rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, flush, wb_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic stall, pc_write, if_id_write, id_ex_bubble, wb_err;
  logic [2:0] outstanding;
  logic [CNT_W-1:0] stall_cycles;

  hazard_scoreboard #(.MAX_LOADS(ML), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .outstanding(outstanding),
    .stall_cycles(stall_cycles), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int  pend_m[$];
  bit  err_m;
  int  sc_m;
  bit  known = 1'b0;
  bit  last_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_pend(int r);
    foreach (pend_m[i]) if (pend_m[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic in_t idle();
    in_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic in_t lw(int rd);
    in_t s = idle();
    s.v = 1; s.rw = 1; s.ld = 1; s.u1 = 1; s.rs1 = 5'd0; s.rd = 5'(rd);
    return s;
  endfunction

  function automatic in_t alu(int rd, int rs1, int rs2);
    in_t s = idle();
    s.v = 1; s.rw = 1; s.u1 = 1; s.u2 = 1;
    s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    return s;
  endfunction

  function automatic in_t with_wb(in_t s, int r);
    s.wbv = 1; s.wbr = 5'(r);
    return s;
  endfunction

  task automatic step(input in_t s);
    bit clr, raw, waw, full, st, issue;
    int used;
    rst = s.rst; id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_rd = s.rd; id_reg_write = s.rw;
    id_is_load = s.ld; flush = s.fl; wb_valid = s.wbv; wb_rd = s.wbr;
    if (s.rst) pend_m.delete();
    #2;
    // A writeback only frees a register that really is in flight.
    clr = s.wbv && s.wbr != 0 && is_pend(s.wbr);
    used = pend_m.size() - int'(clr);
    raw = (s.u1 && s.rs1 != 0 && is_pend(s.rs1) && !(clr && s.rs1 == s.wbr))
       || (s.u2 && s.rs2 != 0 && is_pend(s.rs2) && !(clr && s.rs2 == s.wbr));
    waw = s.rw && s.rd != 0 && is_pend(s.rd) && !(clr && s.rd == s.wbr);
    full = s.ld && used == ML;
    st = s.v && !s.fl && (raw || waw || full);
    issue = s.v && !s.fl && !st && s.ld && s.rw && s.rd != 0;
    last_stall = stall;
    check("stall", stall, st);
    check("pc_write", pc_write, !st);
    check("if_id_write", if_id_write, !st);
    check("id_ex_bubble", id_ex_bubble, st || s.fl);
    if (known && !s.rst) begin
      check("outstanding", outstanding, pend_m.size());
      check("stall_cycles", stall_cycles, sc_m);
      check("wb_err", wb_err, err_m);
    end
    @(posedge clk);
    if (s.rst) begin
      pend_m.delete(); err_m = 0; sc_m = 0; known = 1;
    end else begin
      if (clr) foreach (pend_m[i]) if (pend_m[i] == s.wbr) begin pend_m.delete(i); break; end
      if (issue) pend_m.push_back(s.rd);
      if (s.wbv && !clr) err_m = 1;
      if (st && sc_m < (1 << CNT_W) - 1) sc_m++;
    end
    #1;
  endtask

  initial begin
    in_t s;
    s = idle(); s.rst = 1;
    step(s);
    check("rst_outstanding", outstanding, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_wb_err", wb_err, 0);

    // lw x5 ; add x6,x5,x1 stalls until x5 writes back
    step(lw(5));
    check("lw5_outstanding", outstanding, 1);
    for (int i = 0; i < 3; i++) begin
      step(alu(6, 5, 1));
      check("raw_stall", last_stall, 1);
    end
    step(with_wb(alu(6, 5, 1), 5));
    check("raw_release", last_stall, 0);
    check("raw_outstanding", outstanding, 0);

    // lw x0 is not tracked
    step(lw(0));
    step(alu(6, 0, 0));
    check("x0_stall", last_stall, 0);
    check("x0_outstanding", outstanding, 0);

    // capacity: third load stalls, then issues alongside a writeback
    step(lw(1));
    step(lw(2));
    step(lw(3));
    check("full_stall", last_stall, 1);
    step(with_wb(lw(3), 1));
    check("full_release", last_stall, 0);
    check("full_outstanding", outstanding, 2);

    // WAW with flush
    step(with_wb(idle(), 2));
    step(with_wb(idle(), 3));
    step(lw(7));
    s = alu(7, 0, 0); s.u2 = 0;
    step(s);
    check("waw_stall", last_stall, 1);
    s.fl = 1;
    step(s);
    check("flush_stall", last_stall, 0);
    check("flush_bubble", id_ex_bubble, 1);
    s.fl = 0;
    step(s);
    check("waw_still_pending", last_stall, 1);

    // writeback to a non-pending register
    step(with_wb(idle(), 9));
    check("wb_err_set", wb_err, 1);
    check("wb_err_cnt", outstanding, 1);
    step(idle());
    check("wb_err_sticky", wb_err, 1);

    // reset with a load outstanding
    step(lw(4));
    s = idle(); s.rst = 1;
    step(s);
    check("rst2_outstanding", outstanding, 0);
    check("rst2_stall_cycles", stall_cycles, 0);
    check("rst2_wb_err", wb_err, 0);
    step(alu(8, 7, 4));
    check("rst2_dep_proceeds", last_stall, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 199) == 0);
      s.v   = ($urandom_range(0, 3) != 0);
      s.rs1 = 5'($urandom_range(0, 7));
      s.rs2 = 5'($urandom_range(0, 7));
      s.rd  = 5'($urandom_range(0, 7));
      s.u1  = $urandom_range(0, 1);
      s.u2  = $urandom_range(0, 1);
      s.rw  = ($urandom_range(0, 4) != 0);
      s.ld  = $urandom_range(0, 1);
      s.fl  = ($urandom_range(0, 9) == 0);
      s.wbv = ($urandom_range(0, 2) == 0);
      if (pend_m.size() > 0 && $urandom_range(0, 9) != 0)
        s.wbr = 5'(pend_m[$urandom_range(0, pend_m.size() - 1)]);
      else
        s.wbr = 5'($urandom_range(0, 31));
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
